hall_input_conditioner: RTL and testbench



---
 rtl/hall_pkg.sv | 39 +++
 rtl/hall_glitch_filter.sv | 45 ++++
 rtl/hall_input_conditioner.sv | 89 ++++++++
 tb/tb_hall_input_conditioner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hall_pkg.sv
// Shared hall-sensor constants and commutation-sequence helpers.
package hall_pkg;

  localparam logic [2:0] HALL_BAD_LO = 3'b000;
  localparam logic [2:0] HALL_BAD_HI = 3'b111;
  localparam logic [2:0] IDX_BAD     = 3'd7;
  localparam logic [2:0] IDX_LAST    = 3'd5;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  function automatic logic hall_legal(input logic [2:0] code);
    return (code != HALL_BAD_LO) && (code != HALL_BAD_HI);
  endfunction

  // Position in the forward 6-step sequence; illegal codes map to IDX_BAD.
  function automatic logic [2:0] hall_idx(input logic [2:0] code);
    logic [2:0] idx;
    case (code)
      3'b001:  idx = 3'd0;
      3'b011:  idx = 3'd1;
      3'b010:  idx = 3'd2;
      3'b110:  idx = 3'd3;
      3'b100:  idx = 3'd4;
      3'b101:  idx = 3'd5;
      default: idx = IDX_BAD;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] idx_next(input logic [2:0] idx);
    return (idx == IDX_LAST) ? 3'd0 : 3'(idx + 3'd1);
  endfunction

  function automatic logic [2:0] idx_prev(input logic [2:0] idx);
    return (idx == 3'd0) ? IDX_LAST : 3'(idx - 3'd1);
  endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Two-flop synchroniser plus stability counter; strobes accept_c once a new
// code has been seen for FILT_CYCLES consecutive synchronised samples.
module hall_glitch_filter #(
  parameter int unsigned FILT_CYCLES = 16,
  parameter int unsigned FILT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall_in,
  input  logic [2:0] current,
  output logic       accept_c,
  output logic [2:0] code
);

  localparam logic [FILT_W-1:0] CNT_MAX = FILT_W'(FILT_CYCLES - 1);
  // Arm one count early so the accept lands on the FILT_CYCLES-th sample.
  localparam logic [FILT_W-1:0] CNT_ARM = FILT_W'(FILT_CYCLES - 2);

  logic [2:0]        sync1;
  logic [2:0]        sync2;
  logic [FILT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
      code  <= 3'b000;
      cnt   <= '0;
    end else begin
      sync1 <= hall_in;
      sync2 <= sync1;
      if (sync2 != code) begin
        code <= sync2;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + FILT_W'(1);
      end
    end
  end

  always_comb begin
    accept_c = (sync2 == code) && (cnt >= CNT_ARM) && (code != current);
  end

endmodule

// File: rtl/hall_input_conditioner.sv
// Hall front end: filtered code, step/direction pulses and sequence fault
// detection feeding the downstream hall counter.
module hall_input_conditioner
  import hall_pkg::*;
#(
  parameter int unsigned FILT_CYCLES = 16,
  parameter int unsigned FILT_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall_in,
  input  logic       fault_clr,
  output logic [2:0] hall_out,
  output logic       valid,
  output logic       step,
  output logic       dir,
  output logic       illegal,
  output logic       skip,
  output logic       fault
);

  logic       accept_c;
  logic [2:0] cand;
  logic [2:0] idx_new_c;
  logic [2:0] idx_old_c;
  logic       fwd_c;
  logic       rev_c;

  hall_glitch_filter #(
    .FILT_CYCLES(FILT_CYCLES),
    .FILT_W     (FILT_W)
  ) u_filter (
    .clk     (clk),
    .rst     (rst),
    .hall_in (hall_in),
    .current (hall_out),
    .accept_c(accept_c),
    .code    (cand)
  );

  // Adjacency of the candidate against the currently accepted code.
  always_comb begin
    idx_new_c = hall_idx(cand);
    idx_old_c = hall_idx(hall_out);
    fwd_c     = (idx_new_c == idx_next(idx_old_c));
    rev_c     = (idx_new_c == idx_prev(idx_old_c));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hall_out <= 3'b000;
      valid    <= 1'b0;
      step     <= 1'b0;
      dir      <= 1'b0;
      illegal  <= 1'b0;
      skip     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      step    <= 1'b0;
      illegal <= 1'b0;
      skip    <= 1'b0;
      if (fault_clr) begin
        fault <= 1'b0;
      end
      // Fault-setting assignments below come later, so set beats clear.
      if (accept_c) begin
        hall_out <= cand;
        if (!hall_legal(cand)) begin
          valid   <= 1'b0;
          illegal <= 1'b1;
          fault   <= 1'b1;
        end else if (!hall_legal(hall_out)) begin
          valid <= 1'b1;
        end else if (fwd_c) begin
          step <= 1'b1;
          dir  <= DIR_FWD;
        end else if (rev_c) begin
          step <= 1'b1;
          dir  <= DIR_REV;
        end else begin
          valid <= 1'b1;
          skip  <= 1'b1;
          fault <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hall_input_conditioner.sv
// Directed bench for hall_input_conditioner with FILT_CYCLES=4.
module tb_hall_input_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] hall_in = 3'b000;
  logic       fault_clr = 1'b0;
  logic [2:0] hall_out;
  logic       valid, step, dir, illegal, skip, fault;

  int errors = 0;
  int checks = 0;

  hall_input_conditioner #(.FILT_CYCLES(4), .FILT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .hall_in  (hall_in),
    .fault_clr(fault_clr),
    .hall_out (hall_out),
    .valid    (valid),
    .step     (step),
    .dir      (dir),
    .illegal  (illegal),
    .skip     (skip),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a code for n cycles and count the pulses seen.
  task automatic hold(input logic [2:0] code, input int n,
                      output int steps, output int ills, output int skips);
    steps = 0; ills = 0; skips = 0;
    hall_in = code;
    for (int i = 0; i < n; i++) begin
      tick();
      steps += int'(step);
      ills  += int'(illegal);
      skips += int'(skip);
    end
  endtask

  task automatic test_reset();
    int s, il, sk;
    rst = 1'b1; hall_in = 3'b000;
    repeat (3) tick();
    checks++;
    if ({hall_out, valid, step, dir, illegal, skip, fault} !== 9'b0) begin
      errors++;
      $display("FAIL reset_state: got %b want 000000000",
               {hall_out, valid, step, dir, illegal, skip, fault});
    end
    rst = 1'b0;
    hold(3'b000, 20, s, il, sk);
    checks++;
    if (valid !== 1'b0 || il != 0 || hall_out !== 3'b000) begin
      errors++;
      $display("FAIL idle_000: valid=%b illegal_pulses=%0d hall_out=%b want 0/0/000",
               valid, il, hall_out);
    end
  endtask

  task automatic test_first_code();
    hall_in = 3'b001;
    repeat (5) tick();
    checks++;
    if (hall_out !== 3'b000 || valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: edge5 hall_out=%b valid=%b want 000/0", hall_out, valid);
    end
    tick();
    checks++;
    if (hall_out !== 3'b001 || valid !== 1'b1 || step !== 1'b0 ||
        illegal !== 1'b0 || skip !== 1'b0) begin
      errors++;
      $display("FAIL first_code: edge6 hall_out=%b valid=%b step=%b ill=%b skip=%b want 001/1/0/0/0",
               hall_out, valid, step, illegal, skip);
    end
  endtask

  task automatic test_forward();
    logic [2:0] seq [6] = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
    int s, il, sk, ts, tsk;
    ts = 0; tsk = 0;
    for (int i = 0; i < 6; i++) begin
      hold(seq[i], 20, s, il, sk);
      ts += s; tsk += sk + il;
    end
    checks++;
    if (ts != 6 || tsk != 0 || dir !== 1'b1 || fault !== 1'b0 || hall_out !== 3'b001) begin
      errors++;
      $display("FAIL forward_seq: steps=%0d bad=%0d dir=%b fault=%b hall_out=%b want 6/0/1/0/001",
               ts, tsk, dir, fault, hall_out);
    end
  endtask

  task automatic test_reverse();
    logic [2:0] seq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    int s, il, sk, ts, tsk;
    ts = 0; tsk = 0;
    for (int i = 0; i < 6; i++) begin
      hold(seq[i], 20, s, il, sk);
      ts += s; tsk += sk + il;
    end
    checks++;
    if (ts != 6 || tsk != 0 || dir !== 1'b0 || fault !== 1'b0 || hall_out !== 3'b001) begin
      errors++;
      $display("FAIL reverse_seq: steps=%0d bad=%0d dir=%b fault=%b hall_out=%b want 6/0/0/0/001",
               ts, tsk, dir, fault, hall_out);
    end
  endtask

  task automatic test_glitch();
    int s, il, sk, s2, il2, sk2;
    hold(3'b011, 20, s, il, sk);
    hold(3'b010, 2, s, il, sk);
    hold(3'b011, 20, s2, il2, sk2);
    checks++;
    if (hall_out !== 3'b011 || (s + il + sk + s2 + il2 + sk2) != 0) begin
      errors++;
      $display("FAIL glitch: hall_out=%b pulses=%0d want 011/0",
               hall_out, s + il + sk + s2 + il2 + sk2);
    end
  endtask

  task automatic test_illegal();
    int s, il, sk;
    hold(3'b010, 20, s, il, sk);
    hold(3'b111, 10, s, il, sk);
    checks++;
    if (hall_out !== 3'b111 || valid !== 1'b0 || il != 1 || fault !== 1'b1 ||
        s != 0 || dir !== 1'b1) begin
      errors++;
      $display("FAIL illegal_code: hall_out=%b valid=%b ill=%0d fault=%b steps=%0d dir=%b want 111/0/1/1/0/1",
               hall_out, valid, il, fault, s, dir);
    end
    hold(3'b110, 20, s, il, sk);
    checks++;
    if (valid !== 1'b1 || s != 0 || sk != 0 || hall_out !== 3'b110 || fault !== 1'b1) begin
      errors++;
      $display("FAIL recover_legal: valid=%b steps=%0d skips=%0d hall_out=%b fault=%b want 1/0/0/110/1",
               valid, s, sk, hall_out, fault);
    end
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: fault=%b want 0", fault);
    end
  endtask

  task automatic test_skip();
    int s, il, sk;
    hold(3'b010, 20, s, il, sk);
    hold(3'b011, 20, s, il, sk);
    hold(3'b001, 20, s, il, sk);
    checks++;
    if (dir !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL skip_setup: dir=%b fault=%b want 0/0", dir, fault);
    end
    hold(3'b110, 20, s, il, sk);
    checks++;
    if (sk != 1 || s != 0 || fault !== 1'b1 || dir !== 1'b0 ||
        hall_out !== 3'b110 || valid !== 1'b1) begin
      errors++;
      $display("FAIL skip: skips=%0d steps=%0d fault=%b dir=%b hall_out=%b valid=%b want 1/0/1/0/110/1",
               sk, s, fault, dir, hall_out, valid);
    end
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
  endtask

  task automatic test_clr_collision();
    hall_in = 3'b001;
    repeat (5) tick();
    fault_clr = 1'b1;
    tick();
    checks++;
    if (skip !== 1'b1 || fault !== 1'b1 || hall_out !== 3'b001) begin
      errors++;
      $display("FAIL clr_vs_set: skip=%b fault=%b hall_out=%b want 1/1/001", skip, fault, hall_out);
    end
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || skip !== 1'b0) begin
      errors++;
      $display("FAIL clr_after: fault=%b skip=%b want 0/0", fault, skip);
    end
  endtask

  task automatic test_reset_mid();
    int s, il, sk;
    hold(3'b110, 20, s, il, sk);   // skip from 001 sets fault before reset
    hall_in = 3'b010;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({hall_out, valid, step, dir, illegal, skip, fault} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid: got %b want 000000000",
               {hall_out, valid, step, dir, illegal, skip, fault});
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (step !== 1'b0 || illegal !== 1'b0 || skip !== 1'b0 || hall_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: step=%b ill=%b skip=%b hall_out=%b want 0/0/0/000",
               step, illegal, skip, hall_out);
    end
    hold(3'b010, 20, s, il, sk);
    checks++;
    if (hall_out !== 3'b010 || valid !== 1'b1 || (s + il + sk) != 0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_code: hall_out=%b valid=%b pulses=%0d fault=%b want 010/1/0/0",
               hall_out, valid, s + il + sk, fault);
    end
  endtask

  initial begin
    test_reset();
    test_first_code();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_skip();
    test_clr_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
